// File: rtl/sampling_pkg.sv
// sampling_pkg: FSM state encoding, default frame geometry and counter widths for the sampling layer sequencer
package sampling_pkg;
   typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_STREAM, S_DRAIN, S_DONE} state_t;
   localparam int IMG_W_DEF         = 24;
   localparam int IMG_H_DEF         = 24;
   localparam int DRAIN_TIMEOUT_DEF = 64;
   localparam int RD_W              = 10;
   localparam int WR_W              = 8;
   localparam int TO_W              = 7;
endpackage

// File: rtl/sampling_frame_counter.sv
// sampling_frame_counter: enabled up-counter that saturates at MAX and flags the terminal count
//   i_clk/i_rst_n : clock, async active-low reset
//   i_clr         : synchronous clear to zero
//   i_en          : count enable, ignored once o_tc is high
//   o_count/o_tc  : current count, terminal-count flag (count == MAX)
module sampling_frame_counter #(
   parameter int W   = 8,
   parameter int MAX = 255
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_clr,
   input  logic         i_en,
   output logic [W-1:0] o_count,
   output logic         o_tc
);
   logic [W-1:0] r_count;
   assign o_count = r_count;
   assign o_tc    = (r_count == W'(MAX));
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_count <= '0;
      else if (i_clr) r_count <= '0;
      else if (i_en && !o_tc) r_count <= r_count + 1'b1;
   end
endmodule

// File: rtl/sampling_layer_sequencer.sv
// sampling_layer_sequencer: streams one feature-map frame into a sampling layer and collects its pooled outputs
//   i_clock/i_input_reset_n : clock, async active-low reset
//   i_start/i_hold          : frame request (IDLE only), read back-pressure
//   o_read_*                : input buffer read strobe/address
//   o_layer_*               : sampling layer reset/valid/finish, i_layer_output_valid from the layer
//   o_write_*               : pooled-output buffer write strobe/address
//   o_busy/o_done/o_frame_error : status; error is sticky until the next accepted start
module sampling_layer_sequencer
   import sampling_pkg::*;
#(
   parameter int IMG_W         = IMG_W_DEF,
   parameter int IMG_H         = IMG_H_DEF,
   parameter int DRAIN_TIMEOUT = DRAIN_TIMEOUT_DEF
) (
   input  logic            i_clock,
   input  logic            i_input_reset_n,
   input  logic            i_start,
   input  logic            i_hold,
   output logic            o_read_enable,
   output logic [RD_W-1:0] o_read_address,
   output logic            o_layer_reset,
   output logic            o_layer_valid,
   output logic            o_layer_finish,
   input  logic            i_layer_output_valid,
   output logic            o_write_enable,
   output logic [WR_W-1:0] o_write_address,
   output logic            o_busy,
   output logic            o_done,
   output logic            o_frame_error
);
   localparam int N_RD = IMG_W * IMG_H;
   localparam int N_WR = (IMG_W / 2) * (IMG_H / 2);
   state_t          r_state;
   logic            r_layer_reset, r_layer_valid, r_last_read, r_layer_finish;
   logic            r_busy, r_done, r_frame_error;
   logic            w_clr, w_rd_en, w_rd_tc, w_wr_win, w_wr_en, w_wr_tc, w_to_tc, w_drain;
   logic [TO_W-1:0] w_to_count_unused;
   assign w_clr    = (r_state == S_CLEAR);
   assign w_drain  = (r_state == S_DRAIN);
   assign w_rd_en  = (r_state == S_STREAM) && !i_hold;
   assign w_wr_win = (r_state == S_STREAM) || w_drain;
   assign w_wr_en  = w_wr_win && i_layer_output_valid && !w_wr_tc;
   sampling_frame_counter #(.W(RD_W), .MAX(N_RD - 1)) u_rd_cnt (
      .i_clk(i_clock), .i_rst_n(i_input_reset_n), .i_clr(w_clr), .i_en(w_rd_en),
      .o_count(o_read_address), .o_tc(w_rd_tc)
   );
   sampling_frame_counter #(.W(WR_W), .MAX(N_WR)) u_wr_cnt (
      .i_clk(i_clock), .i_rst_n(i_input_reset_n), .i_clr(w_clr), .i_en(w_wr_en),
      .o_count(o_write_address), .o_tc(w_wr_tc)
   );
   // counts DRAIN cycles; terminal count on the last permitted DRAIN cycle
   sampling_frame_counter #(.W(TO_W), .MAX(DRAIN_TIMEOUT - 1)) u_to_cnt (
      .i_clk(i_clock), .i_rst_n(i_input_reset_n), .i_clr(w_clr), .i_en(w_drain),
      .o_count(w_to_count_unused), .o_tc(w_to_tc)
   );
   always_ff @(posedge i_clock or negedge i_input_reset_n) begin
      if (!i_input_reset_n) begin
         r_state        <= S_IDLE;
         r_layer_reset  <= 1'b0;
         r_layer_valid  <= 1'b0;
         r_last_read    <= 1'b0;
         r_layer_finish <= 1'b0;
         r_busy         <= 1'b0;
         r_done         <= 1'b0;
         r_frame_error  <= 1'b0;
      end else begin
         // buffer data arrives one cycle after the read; finish follows the final valid by one more
         r_layer_valid  <= w_rd_en;
         r_last_read    <= w_rd_en && w_rd_tc;
         r_layer_finish <= r_last_read;
         if (w_wr_win && i_layer_output_valid && w_wr_tc) r_frame_error <= 1'b1;
         case (r_state)
            S_IDLE: if (i_start) begin
               r_state       <= S_CLEAR;
               r_layer_reset <= 1'b1;
               r_busy        <= 1'b1;
               r_frame_error <= 1'b0;
            end
            S_CLEAR: begin
               r_state       <= S_STREAM;
               r_layer_reset <= 1'b0;
            end
            S_STREAM: if (w_rd_en && w_rd_tc) r_state <= S_DRAIN;
            S_DRAIN: if (w_wr_tc || w_to_tc) begin
               r_state <= S_DONE;
               r_done  <= 1'b1;
               if (!w_wr_tc) r_frame_error <= 1'b1;
            end
            S_DONE: begin
               r_state <= S_IDLE;
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end
   assign o_read_enable  = w_rd_en;
   assign o_layer_reset  = r_layer_reset;
   assign o_layer_valid  = r_layer_valid;
   assign o_layer_finish = r_layer_finish;
   assign o_write_enable = w_wr_en;
   assign o_busy         = r_busy;
   assign o_done         = r_done;
   assign o_frame_error  = r_frame_error;
endmodule

// File: tb/tb_sampling_layer_sequencer.sv
// tb_sampling_layer_sequencer: directed frames with randomized hold/output timing against a frame-level reference model
module tb_sampling_layer_sequencer;
   localparam int NR = 576;
   localparam int NW = 144;
   localparam int TO = 64;
   logic       clk = 0, rst_n = 1, start = 0, hold = 0, lov = 0;
   logic       re, lr, lv, lf, we, busy, done, ferr;
   logic [9:0] ra;
   logic [7:0] wa;
   int         total = 0, bad = 0;
   always #5 clk = ~clk;
   sampling_layer_sequencer dut (
      .i_clock(clk), .i_input_reset_n(rst_n), .i_start(start), .i_hold(hold),
      .o_read_enable(re), .o_read_address(ra), .o_layer_reset(lr), .o_layer_valid(lv),
      .o_layer_finish(lf), .i_layer_output_valid(lov), .o_write_enable(we),
      .o_write_address(wa), .o_busy(busy), .o_done(done), .o_frame_error(ferr)
   );
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask
   // Layer model: one pooled output per 4 valid pixels, capped at n_out; outputs past NW are
   // issued back to back after the NW-th. Cycle 0 carries Start, cycle 1 is the reset cycle.
   task automatic run_frame(input int n_out, input int hold_at, input int hold_len,
                            input int stray_at, input int rst_at, input bit jitter);
      int reads = 0, writes = 0, lvs = 0, sched = 0, pend = 0, held = 0;
      int last_lv = -10, ds = -1, full_cyc = -1, done_at = -1, k;
      bit prev_re = 0, lv_m, ov_err = 0, tmo = 0, exp_re, exp_we, stray = 0, fin = 0, forced;
      for (int cyc = 0; cyc < 4000 && !fin; cyc++) begin
         @(negedge clk);
         if (rst_at >= 0 && reads >= rst_at) begin
            rst_n = 0; start = 0; hold = 0; lov = 0;
            #1;
            chk("reset_outputs", {re, ra, lr, lv, lf, we, wa, busy, done, ferr}, 0);
            repeat (3) begin
               @(negedge clk);
               chk("reset_no_done", {done, busy}, 0);
            end
            rst_n = 1;
            @(negedge clk);
            chk("post_reset_idle", {busy, done, re}, 0);
            return;
         end
         start  = (cyc == 0) || stray;
         stray  = 0;
         forced = hold_at > 0 && reads == hold_at && held < hold_len;
         if (forced) held++;
         hold = forced || (jitter && $urandom_range(5) == 0);
         lov  = (pend > 0) && (!jitter || $urandom_range(1) == 1);
         if (lov) pend--;
         #1;
         exp_re = (cyc >= 2) && (reads < NR) && !hold;
         if (ds >= 0) begin
            k       = (full_cyc >= 0) ? ((full_cyc + 1 > ds) ? full_cyc + 1 : ds) : ds + TO;
            tmo     = (k + 1 > ds + TO);
            done_at = tmo ? ds + TO : k + 1;
         end
         chk("layer_reset", lr, cyc == 1);
         chk("read_enable", re, exp_re);
         if (cyc >= 2 && reads < NR) chk("read_address", ra, reads);
         lv_m = prev_re;
         chk("layer_valid", lv, lv_m);
         chk("layer_finish", lf, lvs == NR && last_lv == cyc - 1);
         exp_we = lov && writes < NW;
         chk("write_enable", we, exp_we);
         if (exp_we) chk("write_address", wa, writes);
         chk("done", done, done_at >= 0 && cyc == done_at);
         chk("busy", busy, cyc >= 1 && (done_at < 0 || cyc <= done_at));
         if (cyc >= 1) chk("frame_error", ferr, ov_err || (tmo && cyc >= done_at));
         if (done_at >= 0 && cyc == done_at) begin
            chk("reads_total", reads, NR);
            chk("write_count_end", wa, n_out < NW ? n_out : NW);
            if (n_out < NW) chk("drain_cycles", cyc - ds, TO);
         end
         if (done_at >= 0 && cyc == done_at + 1) fin = 1;
         if (lov && writes >= NW) ov_err = 1;
         if (exp_we) begin
            writes++;
            if (writes == NW) full_cyc = cyc;
         end
         if (exp_re) begin
            reads++;
            if (reads == NR) ds = cyc + 1;
            if (stray_at >= 0 && reads == stray_at) stray = 1;
         end
         if (lv_m) begin
            lvs++;
            last_lv = cyc;
            if (lvs % 4 == 0 && sched < n_out && sched < NW) begin
               sched++;
               pend++;
            end
            if (sched == NW && n_out > NW) begin
               pend += n_out - NW;
               sched = n_out;
            end
         end
         prev_re = exp_re;
      end
      chk("frame_completed", fin, 1);
      start = 0; hold = 0; lov = 0;
   endtask
   initial begin
      #2 rst_n = 0;
      #1 chk("reset_state", {re, ra, lr, lv, lf, we, wa, busy, done, ferr}, 0);
      repeat (2) @(negedge clk);
      rst_n = 1;
      run_frame(144, -1, 0, -1, -1, 0);
      run_frame(144, 100, 10, -1, -1, 0);
      run_frame(140, -1, 0, -1, -1, 0);
      run_frame(145, -1, 0, -1, -1, 0);
      run_frame(144, -1, 0, 200, -1, 1);
      run_frame(144, -1, 0, -1, 300, 0);
      run_frame(144, -1, 0, -1, -1, 0);
      run_frame(int'($urandom_range(130, 144)), 50, 3, -1, -1, 1);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/sampling_layer_sequencer.md
SAMPLING_LAYER_SEQUENCER -- requirements
Module: sampling_layer_sequencer

Interface
REQ-001 Parameter IMG_W, 24, input feature-map width in pixels.
REQ-002 Parameter IMG_H, 24, input feature-map height in pixels.
REQ-003 Parameter DRAIN_TIMEOUT, 64, maximum DRAIN cycles before error.
REQ-004 Port Clock  in  1  single clock; all state changes on rising edge.
REQ-005 Port Input_Reset_N  in  1  asynchronous, active-low reset.
REQ-006 Port Start  in  1  single-cycle request to process one frame.
REQ-007 Port Hold  in  1  when high, no new buffer read is issued.
REQ-008 Port Read_Enable  out  1  read strobe to the input feature-map buffer.
REQ-009 Port Read_Address  out  10  raster pixel index, 0..IMG_W*IMG_H-1.
REQ-010 Port Layer_Reset  out  1  drives the sampling layer's Input_Reset.
REQ-011 Port Layer_Valid  out  1  drives the sampling layer's Input_Valid; marks buffer data valid.
REQ-012 Port Layer_Finish  out  1  drives the sampling layer's Input_Finish.
REQ-013 Port Layer_Output_Valid  in  1  the sampling layer's Output_Valid.
REQ-014 Port Write_Enable  out  1  write strobe to the pooled-output buffer.
REQ-015 Port Write_Address  out  8  pooled index, 0..(IMG_W/2)*(IMG_H/2)-1.
REQ-016 Port Busy  out  1  high in every state except IDLE.
REQ-017 Port Done  out  1  one-cycle pulse at frame completion.
REQ-018 Port Frame_Error  out  1  sticky; set on timeout or output overrun, cleared by next accepted Start.

Function
REQ-019 The FSM SHALL have states IDLE, CLEAR, STREAM, DRAIN and DONE.
REQ-020 IDLE->CLEAR SHALL occur on Start=1; Start outside IDLE SHALL be ignored.
REQ-021 In CLEAR, Layer_Reset=1 for exactly one cycle, read/write counters zeroed, Frame_Error cleared, then ->STREAM.
REQ-022 In STREAM with Hold=0, Read_Enable=1 and Read_Address increments by 1 per cycle from 0; Hold=1 forces Read_Enable=0 and freezes Read_Address.
REQ-023 Layer_Valid SHALL equal Read_Enable delayed one cycle, matching the buffer's 1-cycle read latency.
REQ-024 After the read of address IMG_W*IMG_H-1, the FSM SHALL enter DRAIN on the next cycle.
REQ-025 Layer_Finish SHALL pulse high for one cycle, the cycle after the final Layer_Valid.
REQ-026 Write_Enable SHALL equal Layer_Output_Valid in STREAM or DRAIN while write count < (IMG_W/2)*(IMG_H/2); Write_Address increments after each write.
REQ-027 Layer_Output_Valid with write count already at (IMG_W/2)*(IMG_H/2) SHALL set Frame_Error and produce no write.
REQ-028 DRAIN->DONE when write count reaches (IMG_W/2)*(IMG_H/2); DRAIN->DONE with Frame_Error=1 after DRAIN_TIMEOUT cycles without completion.
REQ-029 DONE SHALL assert Done for one cycle, then ->IDLE.
REQ-030 Layer_Output_Valid in IDLE, CLEAR or DONE SHALL be ignored.
REQ-031 Counters SHALL never wrap; widths sized exactly for the default parameters (10-bit read, 8-bit write, 7-bit timeout).

Reset
REQ-032 Input_Reset_N=0 SHALL immediately force state IDLE, all counters 0 and every output 0, including Frame_Error.
REQ-033 Reset mid-frame SHALL abandon the frame with no Done pulse; the next Start begins from address 0.

Structure
REQ-034 FSM state encoding, frame-size constants and counter widths SHALL live in shared package sampling_pkg.
REQ-035 One sub-module, sampling_frame_counter (enabled saturating counter with terminal-count flag), SHALL be instantiated for the read, write and timeout counters.

Verification
REQ-036 Start with Hold=0, layer model emitting 144 outputs -> 576 reads on addresses 0..575 in consecutive cycles, Layer_Finish 1 cycle after last Layer_Valid, 144 writes 0..143, Done pulse, Frame_Error=0.
REQ-037 Hold=1 for 10 cycles at address 100 -> Read_Address stays 100, Layer_Valid low 10 cycles, frame still completes with 576 reads total.
REQ-038 Layer model emits only 140 outputs -> DRAIN lasts 64 cycles, Done pulses, Frame_Error=1, Write_Address=140.
REQ-039 Layer model emits 145 outputs -> 144 writes only, Frame_Error=1 set on the 145th.
REQ-040 Input_Reset_N low at address 300 -> all outputs 0 that cycle, no Done; the next Start reads from address 0.
REQ-041 Start pulsed during STREAM -> ignored; exactly one Layer_Reset pulse and one Done pulse per frame.
